// File: rtl/mem_access_if.sv
// Bundle of execute, data-memory, writeback and error signals for mem_access.
// The stage itself connects through "master"; its environment connects through "slave".
interface mem_access_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_mem_op;
  logic [4:0]  ex_rd;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_ready;

  logic        err_misalign;
  logic        err_timeout;
  logic        err_clr;

  modport master (
    input  ex_valid, ex_result, ex_store_data, ex_mem_op, ex_rd,
    output ex_ready,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata,
    output wb_valid, wb_data, wb_rd,
    input  wb_ready,
    output err_misalign, err_timeout,
    input  err_clr
  );

  modport slave (
    output ex_valid, ex_result, ex_store_data, ex_mem_op, ex_rd,
    input  ex_ready,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata,
    input  wb_valid, wb_data, wb_rd,
    output wb_ready,
    input  err_misalign, err_timeout,
    output err_clr
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory request per op, with timeout and
// misalignment detection. Define MEM_SUBWORD_EN to enable LB/LBU/SB byte operations.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WB_HOLD = 2'd2
  } state_e;

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  // The request is live for exactly TIMEOUT_CYCLES cycles; an ack in the last one still wins.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

`ifdef MEM_SUBWORD_EN
  localparam logic SUBWORD = 1'b1;
`else
  localparam logic SUBWORD = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic        ld_byte_q, ld_byte_d;
  logic        ld_sign_q, ld_sign_d;
  logic [1:0]  off_q, off_d;

  logic [31:0] ex_addr;
  logic        dec_load, dec_store, dec_byte, dec_sign, dec_misalign;
  logic        mis_evt, to_evt;
  logic [7:0]  rd_byte;
  logic [31:0] load_word;
  logic        unused_hi;

  assign ex_addr   = bus.ex_result[31:0];
  assign unused_hi = ^bus.ex_result[63:32];

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_byte  = 1'b0;
    dec_sign  = 1'b0;
    case (bus.ex_mem_op)
      OP_LW:  dec_load = 1'b1;
      OP_SW:  dec_store = 1'b1;
      OP_LB: begin
        dec_load = SUBWORD;
        dec_byte = SUBWORD;
        dec_sign = SUBWORD;
      end
      OP_LBU: begin
        dec_load = SUBWORD;
        dec_byte = SUBWORD;
      end
      OP_SB: begin
        dec_store = SUBWORD;
        dec_byte  = SUBWORD;
      end
      default: ;
    endcase
  end

  // Only word accesses have an alignment constraint.
  assign dec_misalign = (dec_load | dec_store) & ~dec_byte & (ex_addr[1:0] != 2'b00);

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus.dm_rdata[7:0];
      2'd1:    rd_byte = bus.dm_rdata[15:8];
      2'd2:    rd_byte = bus.dm_rdata[23:16];
      default: rd_byte = bus.dm_rdata[31:24];
    endcase
    load_word = ld_byte_q ? {{24{ld_sign_q & rd_byte[7]}}, rd_byte} : bus.dm_rdata;
  end

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_be_d    = dm_be_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    cnt_d      = cnt_q;
    is_load_d  = is_load_q;
    ld_byte_d  = ld_byte_q;
    ld_sign_d  = ld_sign_q;
    off_d      = off_q;
    mis_evt    = 1'b0;
    to_evt     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!dec_load && !dec_store) begin
            wb_data_d  = ex_addr;
            wb_rd_d    = bus.ex_rd;
            wb_valid_d = 1'b1;
            state_d    = WB_HOLD;
          end else if (dec_misalign) begin
            mis_evt = 1'b1;
            if (dec_load) begin
              wb_data_d  = 32'h0;
              wb_rd_d    = bus.ex_rd;
              wb_valid_d = 1'b1;
              state_d    = WB_HOLD;
            end
          end else begin
            dm_req_d  = 1'b1;
            dm_we_d   = dec_store;
            dm_addr_d = {ex_addr[31:2], 2'b00};
            if (!dec_store)
              dm_wdata_d = 32'h0;
            else if (dec_byte)
              dm_wdata_d = {4{bus.ex_store_data[7:0]}};
            else
              dm_wdata_d = bus.ex_store_data;
            dm_be_d   = (dec_store && dec_byte) ? (4'b0001 << ex_addr[1:0]) : 4'hF;
            cnt_d     = 8'd0;
            is_load_d = dec_load;
            ld_byte_d = dec_byte;
            ld_sign_d = dec_sign;
            off_d     = ex_addr[1:0];
            if (dec_load)
              wb_rd_d = bus.ex_rd;
            state_d   = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (bus.dm_ack) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (is_load_q) begin
            wb_data_d  = load_word;
            wb_valid_d = 1'b1;
            state_d    = WB_HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == LAST_CNT) begin
          to_evt   = 1'b1;
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (is_load_q) begin
            wb_data_d  = 32'h0;
            wb_valid_d = 1'b1;
            state_d    = WB_HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      WB_HOLD: begin
        if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A clear and a new error event in the same cycle leave the flag set.
    err_mis_d = (err_mis_q & ~bus.err_clr) | mis_evt;
    err_to_d  = (err_to_q & ~bus.err_clr) | to_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_wdata_q <= 32'h0;
      dm_be_q    <= 4'h0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= 5'd0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
      cnt_q      <= 8'd0;
      is_load_q  <= 1'b0;
      ld_byte_q  <= 1'b0;
      ld_sign_q  <= 1'b0;
      off_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_be_q    <= dm_be_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
      cnt_q      <= cnt_d;
      is_load_q  <= is_load_d;
      ld_byte_q  <= ld_byte_d;
      ld_sign_q  <= ld_sign_d;
      off_q      <= off_d;
    end
  end

  assign bus.ex_ready     = (state_q == IDLE);
  assign bus.dm_req       = dm_req_q;
  assign bus.dm_we        = dm_we_q;
  assign bus.dm_addr      = dm_addr_q;
  assign bus.dm_wdata     = dm_wdata_q;
  assign bus.dm_be        = dm_be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_timeout  = err_to_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: each op is predicted from the operation rules and
// compared cycle by cycle against the DUT. Honors MEM_SUBWORD_EN the same way as the RTL.
module tb_mem_access;
  localparam int T = 16;

`ifdef MEM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit exp_mis = 1'b0;
  bit exp_to  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference result of a completed load.
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    if (op == 3'd1) return rdata;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    if (op == 3'd3 && b >= 32'd128) b = b | 32'hFFFF_FF00;
    return b;
  endfunction

  task automatic check_errs(input string tag);
    check_eq({tag, "_err_misalign"}, bus.err_misalign, exp_mis);
    check_eq({tag, "_err_timeout"}, bus.err_timeout, exp_to);
  endtask

  task automatic wb_phase(input logic [31:0] data, input logic [4:0] rd, input int wait_cycles);
    for (int i = 0; i <= wait_cycles; i++) begin
      check_eq("wb_valid", bus.wb_valid, 1'b1);
      check_eq("wb_data", bus.wb_data, data);
      check_eq("wb_rd", bus.wb_rd, rd);
      check_eq("ex_ready_wb", bus.ex_ready, 1'b0);
      if (i == wait_cycles) bus.wb_ready = 1'b1;
      else bus.dm_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.wb_ready = 1'b0;
      bus.dm_ack   = 1'b0;
    end
    check_eq("wb_valid_drop", bus.wb_valid, 1'b0);
    check_eq("ex_ready_back", bus.ex_ready, 1'b1);
  endtask

  task automatic clr_pulse();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    check_errs("clr");
  endtask

  // One op from acceptance to return to IDLE; ack_at >= T means memory never answers.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                        input int wb_wait, input bit clr_with);
    bit is_load, is_store, is_byte, mis, acked;
    logic [31:0] exp_wdata, res;
    logic [3:0]  exp_be;
    is_load  = (op == 3'd1) || (SUB && (op == 3'd3 || op == 3'd4));
    is_store = (op == 3'd2) || (SUB && op == 3'd5);
    is_byte  = SUB && (op >= 3'd3) && (op <= 3'd5);
    mis      = (op == 3'd1 || op == 3'd2) && (addr % 4 != 0);
    res      = 32'h0;

    check_eq("ex_ready_idle", bus.ex_ready, 1'b1);
    bus.ex_valid      = 1'b1;
    bus.ex_result     = {$urandom, addr};
    bus.ex_store_data = sdata;
    bus.ex_mem_op     = op;
    bus.ex_rd         = rd;
    bus.err_clr       = clr_with;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.err_clr  = 1'b0;
    if (clr_with) begin
      exp_mis = 1'b0;
      exp_to  = 1'b0;
    end

    if (!is_load && !is_store) begin
      res = addr;
      check_eq("no_dm_req_none", bus.dm_req, 1'b0);
      wb_phase(addr, rd, wb_wait);
    end else if (mis) begin
      exp_mis = 1'b1;
      check_eq("no_dm_req_mis", bus.dm_req, 1'b0);
      check_errs("mis");
      if (is_load) wb_phase(32'h0, rd, wb_wait);
      else begin
        check_eq("sw_mis_no_wb", bus.wb_valid, 1'b0);
        check_eq("sw_mis_ready", bus.ex_ready, 1'b1);
      end
    end else begin
      exp_be    = (is_store && is_byte) ? (4'b0001 << addr[1:0]) : 4'hF;
      exp_wdata = is_byte ? (sdata & 32'hFF) * 32'h0101_0101 : sdata;
      acked = 1'b0;
      for (int k = 0; k < T; k++) begin
        check_eq("dm_req", bus.dm_req, 1'b1);
        check_eq("dm_addr", bus.dm_addr, addr & 32'hFFFF_FFFC);
        check_eq("dm_we", bus.dm_we, is_store);
        check_eq("dm_be", bus.dm_be, exp_be);
        if (is_store) check_eq("dm_wdata", bus.dm_wdata, exp_wdata);
        check_eq("ex_ready_acc", bus.ex_ready, 1'b0);
        if (k == ack_at) begin
          bus.dm_ack   = 1'b1;
          bus.dm_rdata = rdata;
        end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        if (k == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      check_eq("dm_req_drop", bus.dm_req, 1'b0);
      if (!acked) exp_to = 1'b1;
      check_errs("acc");
      if (is_load) begin
        res = acked ? load_val(op, addr, rdata) : 32'h0;
        wb_phase(res, rd, wb_wait);
      end else begin
        check_eq("store_no_wb", bus.wb_valid, 1'b0);
        check_eq("store_ready", bus.ex_ready, 1'b1);
      end
    end
    check_errs("end");
    $display("op=%0d addr=%08h rd=%0d ack_at=%0d wb=%08h mis=%0b to=%0b",
             op, addr, rd, ack_at, res, exp_mis, exp_to);
  endtask

  initial begin
    bus.ex_valid      = 1'b0;
    bus.ex_result     = 64'h0;
    bus.ex_store_data = 32'h0;
    bus.ex_mem_op     = 3'd0;
    bus.ex_rd         = 5'd0;
    bus.dm_ack        = 1'b0;
    bus.dm_rdata      = 32'h0;
    bus.wb_ready      = 1'b0;
    bus.err_clr       = 1'b0;
    reset             = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ex_ready", bus.ex_ready, 1'b1);
    check_eq("rst_dm_req", bus.dm_req, 1'b0);
    check_eq("rst_dm_be", bus.dm_be, 4'h0);
    check_eq("rst_wb_valid", bus.wb_valid, 1'b0);
    check_errs("rst");
    reset = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'h0000_002A, 32'h0, 5'd5, 0, 32'h0, 0, 1'b0);
    run_op(3'd1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hCAFE_F00D, 1, 1'b0);
    run_op(3'd2, 32'h0000_0102, 32'h1234_5678, 5'd0, 0, 32'h0, 0, 1'b0);
    clr_pulse();
    run_op(3'd2, 32'h0000_0103, 32'h0, 5'd0, 0, 32'h0, 0, 1'b0);
    run_op(3'd1, 32'h0000_0041, 32'h0, 5'd9, 0, 32'h0, 0, 1'b1);
    clr_pulse();
    run_op(3'd1, 32'h0000_0040, 32'h0, 5'd4, 99, 32'h0, 0, 1'b0);
    clr_pulse();
    run_op(3'd1, 32'h0000_0044, 32'h0, 5'd6, T - 1, 32'h5555_AAAA, 0, 1'b0);
    run_op(3'd2, 32'h0000_0048, 32'hDEAD_BEEF, 5'd0, 99, 32'h0, 0, 1'b0);
    run_op(3'd1, 32'h0000_0010, 32'h0, 5'd0, 0, 32'h0BAD_CAFE, 2, 1'b0);
    run_op(3'd3, 32'h0000_0203, 32'h0, 5'd1, 1, 32'h8011_2233, 0, 1'b0);
    run_op(3'd4, 32'h0000_0203, 32'h0, 5'd2, 1, 32'h8011_2233, 0, 1'b0);
    run_op(3'd5, 32'h0000_0201, 32'h0000_00AB, 5'd0, 2, 32'h0, 0, 1'b0);

    // Reset in the middle of an access, followed by a late ack.
    bus.ex_valid  = 1'b1;
    bus.ex_mem_op = 3'd1;
    bus.ex_result = 64'h80;
    bus.ex_rd     = 5'd3;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    check_eq("pre_rst_dm_req", bus.dm_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_dm_req", bus.dm_req, 1'b0);
    check_eq("mid_rst_dm_addr", bus.dm_addr, 32'h0);
    check_eq("mid_rst_dm_be", bus.dm_be, 4'h0);
    check_eq("mid_rst_wb_data", bus.wb_data, 32'h0);
    check_eq("mid_rst_wb_rd", bus.wb_rd, 5'd0);
    check_eq("mid_rst_ex_ready", bus.ex_ready, 1'b1);
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    check_errs("mid_rst");
    @(negedge clk);
    reset        = 1'b1;
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_dm_req", bus.dm_req, 1'b0);
      check_eq("post_rst_wb_valid", bus.wb_valid, 1'b0);
      check_eq("post_rst_ex_ready", bus.ex_ready, 1'b1);
    end
    bus.dm_ack = 1'b0;
    $display("reset during access: request abandoned, late ack ignored");

    for (int n = 0; n < 120; n++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      int          ack_at;
      op     = 3'($urandom_range(0, 7));
      addr   = $urandom;
      if ((op == 3'd1 || op == 3'd2) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      ack_at = $urandom_range(0, T + 3);
      run_op(op, addr, $urandom, 5'($urandom_range(0, 31)), ack_at, $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 15) == 0) clr_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles dm_req waits for dm_ack (legal range 2..255).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have port ex_valid  in  1  execute-stage result valid.
REQ-005 SHALL have port ex_ready  out  1  stage can accept an op this cycle.
REQ-006 SHALL have port ex_result  in  64  execute result; bits[31:0] are the address or pass-through value, bits[63:32] ignored.
REQ-007 SHALL have port ex_store_data  in  32  store data (rt value).
REQ-008 SHALL have port ex_mem_op  in  3  000 NONE, 001 LW, 010 SW, 011 LB, 100 LBU, 101 SB; others treated as NONE.
REQ-009 SHALL have port ex_rd  in  5  destination register.
REQ-010 SHALL have ports dm_req out 1, dm_we out 1, dm_addr out 32, dm_wdata out 32, dm_be out 4  data-memory request.
REQ-011 SHALL have ports dm_ack in 1, dm_rdata in 32  data-memory completion and read data.
REQ-012 SHALL have ports wb_valid out 1, wb_data out 32, wb_rd out 5, wb_ready in 1  writeback handshake.
REQ-013 SHALL have ports err_misalign out 1, err_timeout out 1 (sticky), err_clr in 1.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, WB_HOLD.
REQ-015 ex_ready SHALL be 1 only in IDLE; an op is accepted on a posedge with ex_valid && ex_ready.
REQ-016 NONE accepted: wb_data=ex_result[31:0], wb_rd=ex_rd, wb_valid=1 next cycle, state WB_HOLD.
REQ-017 LW/LB/LBU/SW/SB accepted (aligned): next cycle dm_req=1, dm_addr={addr[31:2],2'b00}, dm_we=1 for stores; state ACCESS.
REQ-018 dm_req, dm_we, dm_addr, dm_wdata, dm_be SHALL remain stable from assertion until the cycle dm_ack is sampled 1; dm_req drops the following cycle.
REQ-019 Load ack: capture dm_rdata, load result into wb_data, wb_valid=1 next cycle, state WB_HOLD.
REQ-020 Store ack: no writeback; return to IDLE next cycle.
REQ-021 WB_HOLD: wb_valid, wb_data, wb_rd held until wb_ready==1 sampled; then IDLE (ex_ready=1 that next cycle).
REQ-022 dm_ack outside ACCESS SHALL be ignored.
REQ-023 Timeout counter SHALL clear on entering ACCESS and increment per cycle without ack; at TIMEOUT_CYCLES without ack: drop dm_req, set err_timeout, loads complete with wb_data=0, stores complete silently.
REQ-024 dm_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (no error).
REQ-025 LW/SW with addr[1:0]!=0 SHALL not issue dm_req, SHALL set err_misalign; LW writes back wb_data=0 one cycle later, SW is discarded.
REQ-026 err_clr SHALL clear both error flags next cycle; a simultaneous new error event SHALL win (flag stays 1).
REQ-027 wb_rd==0 loads SHALL still perform the memory access and handshake.

Reset
REQ-028 reset low SHALL immediately force state IDLE, ex_ready=1, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0, wb_valid=0, wb_data=0, wb_rd=0, both error flags 0, counter 0.
REQ-029 Reset asserted mid-ACCESS SHALL abandon the request; any later dm_ack SHALL be ignored.

Configuration
REQ-030 With MEM_SUBWORD_EN defined: LB/LBU select byte addr[1:0] (little-endian), LB sign-extends, LBU zero-extends; SB drives dm_be=1<<addr[1:0], byte replicated on all four lanes of dm_wdata; LW/SW use dm_be=4'hF.
REQ-031 Without MEM_SUBWORD_EN: ops 011/100/101 SHALL behave as NONE; dm_be SHALL always be 4'hF on requests.

Verification
REQ-032 NONE, ex_result=0x0000_0000_0000_002A, ex_rd=5, wb_ready=1 -> wb_valid one cycle later, wb_data=0x2A, wb_rd=5, no dm_req.
REQ-033 LW addr 0x100, dm_ack after 3 cycles, dm_rdata=0xCAFEF00D -> dm_addr=0x100 held 3 cycles, wb_data=0xCAFEF00D, ex_ready low throughout.
REQ-034 SW addr 0x102 -> no dm_req, err_misalign=1; err_clr pulse -> err_misalign=0.
REQ-035 LW addr 0x40, dm_ack never -> after 16 cycles dm_req=0, err_timeout=1, wb_data=0.
REQ-036 MEM_SUBWORD_EN: LB addr 0x203, dm_rdata=0x80112233 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; SB addr 0x201 data 0xAB -> dm_be=4'b0010, dm_wdata=0xABABABAB.
REQ-037 Reset pulsed during ACCESS, then dm_ack=1 -> all outputs at reset values, no wb_valid.
